// File: rtl/smash_noc_ni_tx.sv
`default_nettype none
// ============================================================================
// Module      : smash_noc_ni_tx
// Description : Network-interface transmitter for one router input port of a
//               smash_noc mesh. Core requests pass a valid/ready handshake
//               into a circular FIFO. Requests with an illegal destination
//               are discarded there and never reach the mesh. The FIFO head
//               feeds a registered output stage that presents one packet to
//               the router under valid/ready flow control.
// Ports       : i_clk, i_rst_n        clock, async active-low reset
//               i_req_*/o_req_ready   core request handshake and payload
//               o_valid/i_ready       router handshake
//               o_addr_*/o_data       presented packet
//               o_drop                one-cycle pulse per discarded request
//               o_level               FIFO occupancy (output reg excluded)
//               o_sent_count,
//               o_drop_count          saturating statistics counters
// Options     : SMASH_NI_TX_STATS_EN  builds the statistics counters; when it
//                                     is undefined both counters read 0
// Revision    : 1.0  initial release
// ============================================================================
module smash_noc_ni_tx #(
   parameter int ADDR_SIZE       = 2,
   parameter int DATA_SIZE       = 32,
   parameter int NUM_ROWS        = 2,
   parameter int NUM_COLUMNS     = 2,
   parameter int ROUTER_ROW_ADDR = 0,
   parameter int ROUTER_COL_ADDR = 0,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_req_valid,
   output logic                            o_req_ready,
   input  logic [ADDR_SIZE-1:0]            i_req_addr_row,
   input  logic [ADDR_SIZE-1:0]            i_req_addr_col,
   input  logic [DATA_SIZE-1:0]            i_req_data,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [ADDR_SIZE-1:0]            o_addr_row,
   output logic [ADDR_SIZE-1:0]            o_addr_col,
   output logic [DATA_SIZE-1:0]            o_data,
   output logic                            o_drop,
   output logic [$clog2(FIFO_DEPTH):0]     o_level,
   output logic [15:0]                     o_sent_count,
   output logic [15:0]                     o_drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = 2 * ADDR_SIZE + DATA_SIZE;

   // Address limits are one bit wider so a limit of 2**ADDR_SIZE still fits.
   localparam logic [LVL_W-1:0]     c_depth    = LVL_W'(FIFO_DEPTH);
   localparam logic [ADDR_SIZE:0]   c_num_rows = (ADDR_SIZE+1)'(NUM_ROWS);
   localparam logic [ADDR_SIZE:0]   c_num_cols = (ADDR_SIZE+1)'(NUM_COLUMNS);
   localparam logic [ADDR_SIZE-1:0] c_own_row  = ADDR_SIZE'(ROUTER_ROW_ADDR);
   localparam logic [ADDR_SIZE-1:0] c_own_col  = ADDR_SIZE'(ROUTER_COL_ADDR);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic [0:0]           r_state;
   logic [0:0]           w_state_nxt;
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [LVL_W-1:0]     r_level;
   logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
   logic [ADDR_SIZE-1:0] r_out_row;
   logic [ADDR_SIZE-1:0] r_out_col;
   logic [DATA_SIZE-1:0] r_out_data;
   logic                 r_drop;

   logic w_accept;
   logic w_illegal;
   logic w_push;
   logic w_drop;
   logic w_xfer;
   logic w_pop;
   logic w_fifo_nonempty;

   // ---------------------------------------------------------------------
   // Input handshake and destination filter
   // ---------------------------------------------------------------------
   assign o_req_ready = (r_level != c_depth);
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_illegal   = ({1'b0, i_req_addr_row} >= c_num_rows) ||
                        ({1'b0, i_req_addr_col} >= c_num_cols) ||
                        ((i_req_addr_row == c_own_row) && (i_req_addr_col == c_own_col));
   assign w_push      = w_accept && !w_illegal;
   assign w_drop      = w_accept &&  w_illegal;

   // The pop only looks at the occupancy register, so a push into an empty
   // FIFO becomes poppable on the following edge (no bypass).
   assign w_fifo_nonempty = (r_level != '0);
   assign w_xfer          = (r_state == S_FULL) && i_ready;
   assign w_pop           = w_fifo_nonempty && ((r_state == S_EMPTY) || i_ready);

   // ---------------------------------------------------------------------
   // FIFO storage (data only, no reset needed) and control
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {i_req_addr_row, i_req_addr_col, i_req_data};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_drop   <= 1'b0;
      end else begin
         r_drop <= w_drop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output stage: state register / next state / outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_fifo_nonempty) w_state_nxt = S_FULL;
         S_FULL:  if (w_xfer && !w_fifo_nonempty) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_comb begin
      o_valid = (r_state == S_FULL);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_row  <= '0;
         r_out_col  <= '0;
         r_out_data <= '0;
      end else if (w_pop) begin
         {r_out_row, r_out_col, r_out_data} <= r_mem[r_rd_ptr];
      end
   end

   assign o_addr_row = r_out_row;
   assign o_addr_col = r_out_col;
   assign o_data     = r_out_data;
   assign o_drop     = r_drop;
   assign o_level    = r_level;

   // ---------------------------------------------------------------------
   // Statistics
   // ---------------------------------------------------------------------
`ifdef SMASH_NI_TX_STATS_EN
   logic [15:0] r_sent_count;
   logic [15:0] r_drop_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sent_count <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_xfer && (r_sent_count != 16'hFFFF)) begin
            r_sent_count <= r_sent_count + 16'd1;
         end
         if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
         end
      end
   end

   assign o_sent_count = r_sent_count;
   assign o_drop_count = r_drop_count;
`else
   assign o_sent_count = 16'h0000;
   assign o_drop_count = 16'h0000;
`endif

endmodule
`default_nettype wire
